// File: rtl/rr_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rr_dispatch_pkg
// Purpose  : Shared constants for the 4-channel round-robin dispatcher:
//            channel count, select width and the output-stage state codes.
// Revision : 1.0  initial release
// ============================================================================
package rr_dispatch_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    // Output-stage occupancy: EMPTY holds nothing, HOLD holds one item.
    typedef logic [0:0] state_t;
    localparam state_t EMPTY = 1'b0;
    localparam state_t HOLD  = 1'b1;

    // Channel after c, wrapping 3 -> 0 through the natural 2-bit overflow.
    function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] c);
        return c + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick_4.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick_4
// Purpose  : Combinational ready-search. Returns the first channel with its
//            req bit set, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
//            When no request is set, pick falls back to ptr and found is 0.
// Ports    : ptr   [1:0] in   search start channel
//            req   [3:0] in   per-channel request/ready
//            pick  [1:0] out  chosen channel
//            found       out  at least one req bit set
// Revision : 1.0  initial release
// ============================================================================
module rr_pick_4
    import rr_dispatch_pkg::*;
(
    input  logic [1:0] ptr,
    input  logic [3:0] req,
    output logic [1:0] pick,
    output logic       found
);

    logic [SEL_W-1:0] w_c;

    // Walk the offsets from farthest to nearest so the nearest ready
    // channel is the last (and therefore winning) assignment.
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        w_c   = ptr;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_c = ptr + SEL_W'(k);
            if (req[w_c]) begin
                pick  = w_c;
                found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_dispatch_4.sv
`default_nettype none
// ============================================================================
// Module   : rr_dispatch_4
// Purpose  : One-deep registered dispatcher routing an upstream stream onto
//            four downstream channels in round-robin order. In strict mode
//            (skip_en=0) the next channel is always taken; in skip mode the
//            first ready channel from the pointer onward is chosen. The
//            channel is fixed at load time and held until the transfer.
// Ports    : clk, rst_n (async, active-low)
//            in_valid / in_data / in_ready   upstream handshake
//            skip_en                         0 strict, 1 skip not-ready
//            ch_ready [3:0]                  downstream ready per channel
//            sel [1:0]                       demux select (register output)
//            out_valid [3:0]                 one-hot valid, 1<<sel when held
//            out_data [WIDTH-1:0]            held payload
//            disp_cnt [CNT_W-1:0]            completed transfer count
// Revision : 1.0  initial release
// ============================================================================
module rr_dispatch_4
    import rr_dispatch_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             skip_en,
    input  logic [3:0]       ch_ready,
    output logic [1:0]       sel,
    output logic [3:0]       out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] disp_cnt
);

    state_t           r_state;
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] r_sel;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_cnt;
    // Set on the first edge after reset release; keeps in_ready low until
    // then rather than letting it rise the instant rst_n goes high.
    logic             r_run;

    logic             w_hold;
    logic             w_xfer;
    logic             w_accept;
    logic [SEL_W-1:0] w_start;
    logic [SEL_W-1:0] w_pick;
    logic             w_found;
    logic [SEL_W-1:0] w_load_sel;

    assign w_hold = (r_state == HOLD);
    assign w_xfer = w_hold && ch_ready[r_sel];

    // in_ready depends on state and ch_ready only, never on in_valid.
    assign in_ready = r_run && (!w_hold || w_xfer);
    assign w_accept = in_valid && in_ready;

    // On a pass-through cycle the pointer has not yet advanced in the
    // register, so the search starts from the channel after the one
    // currently leaving.
    assign w_start = w_xfer ? next_ch(r_sel) : r_ptr;

    rr_pick_4 u_pick (
        .ptr   (w_start),
        .req   (ch_ready),
        .pick  (w_pick),
        .found (w_found)
    );

    assign w_load_sel = (skip_en && w_found) ? w_pick : w_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_data  <= '0;
            r_cnt   <= '0;
            r_run   <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_xfer) begin
                r_ptr <= next_ch(r_sel);
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_accept) begin
                r_state <= HOLD;
                r_sel   <= w_load_sel;
                r_data  <= in_data;
            end else if (w_xfer) begin
                r_state <= EMPTY;
            end
        end
    end

    // sel is the select register itself so it can drive the demux directly.
    assign sel       = r_sel;
    assign out_valid = w_hold ? (4'b0001 << r_sel) : 4'b0000;
    assign out_data  = r_data;
    assign disp_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rr_dispatch_4.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_dispatch_4
// Purpose  : Self-checking bench for rr_dispatch_4 (CNT_W=4 to reach the
//            counter wrap quickly). A behavioural model tracks the held item,
//            pointer and count; directed scenarios are followed by random
//            traffic.
// Revision : 1.0  initial release
// ============================================================================
module tb_rr_dispatch_4;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic             skip_en = 1'b0;
    logic [3:0]       ch_ready = 4'b0000;
    logic [1:0]       sel;
    logic [3:0]       out_valid;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] disp_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_hold;
    int m_sel;
    int m_item;
    int m_ptr;
    int m_cnt;
    bit m_run;

    rr_dispatch_4 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .skip_en   (skip_en),
        .ch_ready  (ch_ready),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .disp_cnt  (disp_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hold = 0; m_sel = 0; m_item = 0; m_ptr = 0; m_cnt = 0; m_run = 0;
    endtask

    // One clock cycle: drive inputs after the falling edge, compare outputs
    // against the model, then advance the model across the rising edge.
    task automatic cyc(input bit v, input int d, input bit sk, input logic [3:0] rdy);
        bit xfer, rdy_m, acc;
        int start, chosen;
        @(negedge clk);
        in_valid = v; in_data = d[WIDTH-1:0]; skip_en = sk; ch_ready = rdy;
        #1;
        xfer  = m_hold && rdy[m_sel];
        rdy_m = m_run && (!m_hold || xfer);
        acc   = v && rdy_m;
        chk("in_ready",  32'(in_ready),  32'(rdy_m));
        chk("out_valid", 32'(out_valid), m_hold ? (32'd1 << m_sel) : 32'd0);
        chk("sel",       32'(sel),       32'(m_sel));
        chk("out_data",  32'(out_data),  32'(m_item));
        chk("disp_cnt",  32'(disp_cnt),  32'(m_cnt));
        start  = xfer ? (m_sel + 1) % 4 : m_ptr;
        chosen = start;
        if (sk) begin
            for (int k = 3; k >= 0; k--)
                if (rdy[(start + k) % 4]) chosen = (start + k) % 4;
        end
        @(posedge clk);
        m_run = 1;
        if (xfer) begin
            m_ptr  = (m_sel + 1) % 4;
            m_cnt  = (m_cnt + 1) % 16;
            m_hold = 0;
        end
        if (acc) begin
            m_hold = 1; m_sel = chosen; m_item = d % 256;
        end
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_disp_cnt",  32'(disp_cnt),  32'd0);
        chk("rst_sel",       32'(sel),       32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        model_reset();
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        m_run = 1;
        #1;
        chk("run_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [3:0] r;
        model_reset();
        pulse_reset();

        // Strict mode, back-to-back items A0..A3 on channels 0..3
        for (int i = 0; i < 4; i++) cyc(1, 8'hA0 + i, 0, 4'b1111);
        cyc(0, 0, 0, 4'b1111);
        cyc(0, 0, 0, 4'b1111);
        chk("strict_cnt4", 32'(disp_cnt), 32'd4);

        // Move ptr to 1, then strict stall on channel 1
        cyc(1, 8'hB0, 0, 4'b1111);
        cyc(0, 0, 0, 4'b1111);
        cyc(1, 8'hB1, 0, 4'b1101);
        cyc(0, 0, 0, 4'b1101);
        chk("stall_sel1",   32'(sel),      32'd1);
        chk("stall_ready0", 32'(in_ready), 32'd0);
        cyc(0, 0, 0, 4'b1111);

        // Skip mode from ptr=2 with only channel 0 ready
        cyc(1, 8'hC0, 1, 4'b0001);
        cyc(0, 0, 1, 4'b0001);
        // ptr now 1; one strict transfer on channel 1 brings it to 2
        cyc(1, 8'hC1, 0, 4'b1111);
        cyc(0, 0, 0, 4'b1111);
        // Skip mode with nothing ready falls back to ptr=2
        cyc(1, 8'hC2, 1, 4'b0000);
        cyc(0, 0, 1, 4'b0000);
        chk("skip_none_sel2", 32'(sel), 32'd2);
        cyc(0, 0, 1, 4'b1011);
        chk("skip_hold_data", 32'(out_data), 32'hC2);
        cyc(0, 0, 0, 4'b0100);

        // Stability while holding on channel 3 (ptr=3)
        cyc(1, 8'hD0, 0, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            r = 4'($urandom) & 4'b0111;
            cyc(0, 0, 1'($urandom), r);
            chk("stab_sel",   32'(sel),       32'd3);
            chk("stab_data",  32'(out_data),  32'hD0);
            chk("stab_onehot", 32'(out_valid), 32'b1000);
        end
        cyc(0, 0, 0, 4'b1000);
        // ptr wrapped 3 -> 0
        cyc(1, 8'hE0, 0, 4'b0000);
        cyc(0, 0, 0, 4'b0000);
        chk("wrap_ptr_sel0", 32'(sel), 32'd0);
        cyc(0, 0, 0, 4'b0001);

        // Mid-operation reset while holding 0x5A
        cyc(1, 8'h5A, 0, 4'b0000);
        cyc(0, 0, 0, 4'b0000);
        chk("hold_5a", 32'(out_data), 32'h5A);
        pulse_reset();
        cyc(1, 8'h33, 0, 4'b0000);
        cyc(0, 0, 0, 4'b0000);
        chk("post_rst_sel0", 32'(sel), 32'd0);
        chk("post_rst_cnt0", 32'(disp_cnt), 32'd0);
        cyc(0, 0, 0, 4'b1111);

        // Counter wrap: 16 more transfers after the one above -> 17 total
        for (int i = 0; i < 16; i++) cyc(1, i, 0, 4'b1111);
        cyc(0, 0, 0, 4'b1111);
        cyc(0, 0, 0, 4'b1111);
        chk("cnt_wrap_17", 32'(disp_cnt), 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)),
                1'($urandom), 4'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
